// File: rtl/alu_share_ctrl.sv
// ----------------------------------------------------------------------------
// alu_share_ctrl
//   Sequencer/arbiter that shares one combinational ALU between two
//   requesters. One operation is accepted at a time over a valid/ready
//   handshake. Its operands and opcode are held on the ALU inputs while the
//   operation executes. The ALU result is then registered and returned with
//   its zero flag and the requester index over a valid/ready response channel.
//
//   Flow per operation: IDLE (arbitrate/accept) -> EXEC (1 cycle, or
//   MUL_CYCLES cycles for a `MUL) -> RESP (hold until consumed) -> IDLE.
//
// Parameters
//   DW          operand/result width; must match the ALU (default `DSIZE)
//   MUL_CYCLES  EXEC cycles spent on a `MUL op (>=1); other ops take 1
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  [1:0]      per-requester request valid (bit i = requester i)
//   req_ready  [1:0]      per-requester accept, at most one bit set
//   req_a      [2*DW-1:0] operand a, requester i at [i*DW +: DW]
//   req_b      [2*DW-1:0] operand b, same packing
//   req_op     [5:0]      3-bit opcode, requester i at [i*3 +: 3]
//   alu_a/alu_b/alu_op    operands and opcode driven to the shared ALU
//   alu_out/alu_zero      result and zero flag from the shared ALU
//   rsp_valid/rsp_ready   response handshake
//   rsp_id     requester index that owns the response
//   rsp_data   registered ALU result
//   rsp_zero   registered ALU zero flag
//   busy       high whenever an operation is in flight (state != IDLE)
//
// Configuration
//   ALU_SHARE_FIXED_PRIO_EN  defined: requester 0 always wins a tie.
//                            undefined (default): round robin on ties.
// ----------------------------------------------------------------------------
`ifndef DSIZE
`define DSIZE 16
`endif
`ifndef MUL
`define MUL 3'b101
`endif

module alu_share_ctrl #(
   parameter int DW         = `DSIZE,
   parameter int MUL_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      req_valid,
   output logic [1:0]      req_ready,
   input  logic [2*DW-1:0] req_a,
   input  logic [2*DW-1:0] req_b,
   input  logic [5:0]      req_op,
   output logic [DW-1:0]   alu_a,
   output logic [DW-1:0]   alu_b,
   output logic [2:0]      alu_op,
   input  logic [DW-1:0]   alu_out,
   input  logic            alu_zero,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic            rsp_id,
   output logic [DW-1:0]   rsp_data,
   output logic            rsp_zero,
   output logic            busy
);

   // Counter only needs to hold MUL_CYCLES-1.
   localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [DW-1:0]   a_q;
   logic [DW-1:0]   b_q;
   logic [2:0]      op_q;
   logic            id_q;
`ifndef ALU_SHARE_FIXED_PRIO_EN
   logic            last_grant;
`endif

   logic            grant_vld;
   logic            grant_id;
   logic [DW-1:0]   sel_a;
   logic [DW-1:0]   sel_b;
   logic [2:0]      sel_op;

   // -------------------------------------------------------------------------
   // Arbitration: only meaningful in IDLE; no grant in any other state.
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default first so that no
      // path through the case leaves it unassigned (which would infer a latch).
      grant_vld = 1'b0;
      grant_id  = 1'b0;
      if (state == IDLE) begin
         case (req_valid)
            2'b01: begin
               grant_vld = 1'b1;
               grant_id  = 1'b0;
            end
            2'b10: begin
               grant_vld = 1'b1;
               grant_id  = 1'b1;
            end
            2'b11: begin
               grant_vld = 1'b1;
`ifdef ALU_SHARE_FIXED_PRIO_EN
               grant_id  = 1'b0;
`else
               grant_id  = ~last_grant;
`endif
            end
            default: begin
               grant_vld = 1'b0;
               grant_id  = 1'b0;
            end
         endcase
      end
   end

   assign req_ready = {grant_vld & grant_id, grant_vld & ~grant_id};

   // Payload of the granted requester.
   assign sel_a  = grant_id ? req_a[2*DW-1:DW] : req_a[DW-1:0];
   assign sel_b  = grant_id ? req_b[2*DW-1:DW] : req_b[DW-1:0];
   assign sel_op = grant_id ? req_op[5:3]      : req_op[2:0];

   // The latched operand registers are cleared on the way back to IDLE, so
   // they can drive the ALU directly and read as zero whenever idle.
   assign alu_a  = a_q;
   assign alu_b  = b_q;
   assign alu_op = op_q;

   assign busy   = (state != IDLE);

   // -------------------------------------------------------------------------
   // Sequencer
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         id_q       <= 1'b0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
         last_grant <= 1'b1;
`endif
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_data   <= '0;
         rsp_zero   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  a_q  <= sel_a;
                  b_q  <= sel_b;
                  op_q <= sel_op;
                  id_q <= grant_id;
`ifndef ALU_SHARE_FIXED_PRIO_EN
                  last_grant <= grant_id;
`endif
                  // cnt counts the extra EXEC cycles still to wait.
                  cnt   <= (sel_op == `MUL) ? CW'(MUL_CYCLES - 1) : '0;
                  state <= EXEC;
               end
            end

            EXEC: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  rsp_data  <= alu_out;
                  rsp_zero  <= alu_zero;
                  rsp_id    <= id_q;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end

            RESP: begin
               // rsp_valid is always high here, so rsp_ready alone completes
               // the handshake. No new request is accepted in this cycle.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  a_q       <= '0;
                  b_q       <= '0;
                  op_q      <= '0;
                  state     <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alu_share_ctrl
//   Directed self-checking bench for alu_share_ctrl (DW=16, MUL_CYCLES=3).
//   A small behavioural ALU closes the loop on alu_a/alu_b/alu_op.
//   Inputs are driven on the falling edge; outputs are sampled 1 time unit
//   after the falling edge, well away from the rising (active) edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`ifndef DSIZE
`define DSIZE 16
`endif
`ifndef ADD
`define ADD 3'b000
`endif
`ifndef SUB
`define SUB 3'b001
`endif
`ifndef MUL
`define MUL 3'b101
`endif

module tb_alu_share_ctrl;

   localparam int DW  = 16;
   localparam int MC  = 3;
   localparam logic [2:0] OP_BAD = 3'b111;

   logic            clk;
   logic            rst_n;
   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [2*DW-1:0] req_a;
   logic [2*DW-1:0] req_b;
   logic [5:0]      req_op;
   logic [DW-1:0]   alu_a;
   logic [DW-1:0]   alu_b;
   logic [2:0]      alu_op;
   logic [DW-1:0]   alu_out;
   logic            alu_zero;
   logic            rsp_valid;
   logic            rsp_ready;
   logic            rsp_id;
   logic [DW-1:0]   rsp_data;
   logic            rsp_zero;
   logic            busy;

   int total = 0;
   int bad   = 0;

   alu_share_ctrl #(.DW(DW), .MUL_CYCLES(MC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_out   (alu_out),
      .alu_zero  (alu_zero),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_zero  (rsp_zero),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for the shared ALU; unknown codes give 0 (zero flag set).
   always_comb begin
      alu_out = '0;
      case (alu_op)
         `ADD:    alu_out = alu_a + alu_b;
         `SUB:    alu_out = alu_a - alu_b;
         `MUL:    alu_out = DW'(alu_a * alu_b);
         default: alu_out = '0;
      endcase
      alu_zero = (alu_out == '0);
   end

   task automatic set_req(input int i, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [2:0] op);
      req_a[i*DW +: DW] = a;
      req_b[i*DW +: DW] = b;
      req_op[i*3 +: 3]  = op;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      bit seen;
      #1;
      total++;
      if ({rsp_valid, busy, req_ready, alu_op, rsp_id, rsp_zero} !== 9'd0) begin
         bad++;
         $display("FAIL reset_ctrl: got v=%b busy=%b rdy=%b op=%b id=%b z=%b, want all 0",
                  rsp_valid, busy, req_ready, alu_op, rsp_id, rsp_zero);
      end
      total++;
      if ({alu_a, alu_b, rsp_data} !== '0) begin
         bad++;
         $display("FAIL reset_data: got a=%0d b=%0d data=%0d, want 0", alu_a, alu_b, rsp_data);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Reset in the middle of a MUL.
      @(negedge clk);
      set_req(0, 16'd3, 16'd3, `MUL);
      req_valid = 2'b01;
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      total++;
      if (busy !== 1'b1 || alu_op !== `MUL) begin
         bad++;
         $display("FAIL reset_pre_exec: got busy=%b op=%b, want 1 %b", busy, alu_op, `MUL);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_op !== 3'd0) begin
         bad++;
         $display("FAIL reset_mid_exec: got v=%b busy=%b op=%b, want 0 0 000",
                  rsp_valid, busy, alu_op);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         #1;
         if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL reset_no_rsp: got activity after release=1, want 0");
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_single_add();
      @(negedge clk);
      rsp_ready = 1'b0;
      set_req(0, 16'd5, 16'd3, `ADD);
      req_valid = 2'b01;
      #1;
      total++;
      if (req_ready !== 2'b01) begin
         bad++;
         $display("FAIL add_ready: got %b want 01", req_ready);
      end
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      total++;
      if (req_ready !== 2'b00 || busy !== 1'b1 || rsp_valid !== 1'b0 ||
          alu_a !== 16'd5 || alu_b !== 16'd3 || alu_op !== `ADD) begin
         bad++;
         $display("FAIL add_exec: got rdy=%b busy=%b v=%b a=%0d b=%0d op=%b, want 00 1 0 5 3 000",
                  req_ready, busy, rsp_valid, alu_a, alu_b, alu_op);
      end
      @(negedge clk);
      #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'd8 || rsp_zero !== 1'b0 || rsp_id !== 1'b0) begin
         bad++;
         $display("FAIL add_rsp: got v=%b data=%0d z=%b id=%b, want 1 8 0 0",
                  rsp_valid, rsp_data, rsp_zero, rsp_id);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || alu_op !== 3'd0 || alu_a !== '0) begin
         bad++;
         $display("FAIL add_idle: got busy=%b v=%b op=%b a=%0d, want 0 0 000 0",
                  busy, rsp_valid, alu_op, alu_a);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_mul();
      @(negedge clk);
      rsp_ready = 1'b0;
      set_req(1, 16'd6, 16'd7, `MUL);
      req_valid = 2'b10;
      #1;
      total++;
      if (req_ready !== 2'b10) begin
         bad++;
         $display("FAIL mul_ready: got %b want 10", req_ready);
      end
      for (int k = 1; k <= MC; k++) begin
         @(negedge clk);
         req_valid = 2'b00;
         #1;
         total++;
         if (alu_op !== `MUL || alu_a !== 16'd6 || alu_b !== 16'd7 ||
             rsp_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mul_exec%0d: got op=%b a=%0d b=%0d v=%b busy=%b, want 101 6 7 0 1",
                     k, alu_op, alu_a, alu_b, rsp_valid, busy);
         end
      end
      @(negedge clk);
      #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'd42 || rsp_id !== 1'b1 || rsp_zero !== 1'b0) begin
         bad++;
         $display("FAIL mul_rsp: got v=%b data=%0d id=%b z=%b, want 1 42 1 0",
                  rsp_valid, rsp_data, rsp_id, rsp_zero);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL mul_idle: got busy=%b want 0", busy);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_back_to_back();
      logic [1:0] exp_rdy [4];
      int g;
      int r;
`ifdef ALU_SHARE_FIXED_PRIO_EN
      exp_rdy = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
      exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
      do_reset();
      rsp_ready = 1'b1;
      set_req(0, 16'd1, 16'd1, `ADD);
      set_req(1, 16'd2, 16'd2, `ADD);
      req_valid = 2'b11;
      g = 0;
      r = 0;
      for (int cyc = 0; cyc < 40 && (g < 4 || r < 4); cyc++) begin
         #1;
         if (req_ready !== 2'b00 && g < 4) begin
            total++;
            if (req_ready !== exp_rdy[g]) begin
               bad++;
               $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, exp_rdy[g]);
            end
            g++;
         end
         if (rsp_valid === 1'b1 && r < 4) begin
            total++;
            if (rsp_id !== exp_rdy[r][1] ||
                rsp_data !== (exp_rdy[r][1] ? 16'd4 : 16'd2)) begin
               bad++;
               $display("FAIL rr_rsp%0d: got id=%b data=%0d want id=%b data=%0d", r,
                        rsp_id, rsp_data, exp_rdy[r][1], exp_rdy[r][1] ? 4 : 2);
            end
            r++;
         end
         @(negedge clk);
      end
      req_valid = 2'b00;
      total++;
      if (g != 4 || r != 4) begin
         bad++;
         $display("FAIL rr_count: got grants=%0d rsps=%0d want 4 4", g, r);
      end
      @(negedge clk);
   endtask

   // -------------------------------------------------------------------------
   task automatic test_backpressure();
      @(negedge clk);
      rsp_ready = 1'b0;
      set_req(0, 16'd4, 16'd4, `SUB);
      set_req(1, 16'd1, 16'd1, `ADD);
      req_valid = 2'b01;
      @(negedge clk);
      req_valid = 2'b10;     // competing request must stay blocked
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         #1;
         total++;
         if (rsp_valid !== 1'b1 || rsp_data !== 16'd0 || rsp_zero !== 1'b1 ||
             req_ready !== 2'b00 || busy !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold%0d: got v=%b data=%0d z=%b rdy=%b busy=%b, want 1 0 1 00 1",
                     k, rsp_valid, rsp_data, rsp_zero, req_ready, busy);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      req_valid = 2'b00;
      @(negedge clk);
      #1;
      total++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_release: got busy=%b v=%b want 0 0", busy, rsp_valid);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_unknown_op();
      @(negedge clk);
      rsp_ready = 1'b1;
      set_req(1, 16'd9, 16'd9, OP_BAD);
      req_valid = 2'b10;
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      total++;
      if (alu_op !== OP_BAD) begin
         bad++;
         $display("FAIL unk_pass: got op=%b want %b", alu_op, OP_BAD);
      end
      @(negedge clk);
      #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'd0 || rsp_zero !== 1'b1 || rsp_id !== 1'b1) begin
         bad++;
         $display("FAIL unk_rsp: got v=%b data=%0d z=%b id=%b want 1 0 1 1",
                  rsp_valid, rsp_data, rsp_zero, rsp_id);
      end
      @(negedge clk);
   endtask

   // -------------------------------------------------------------------------
   task automatic test_withdrawn();
      int grants;
      int rsps;
      @(negedge clk);
      rsp_ready = 1'b1;
      set_req(1, 16'd10, 16'd20, `ADD);
      set_req(0, 16'd7, 16'd7, `ADD);
      req_valid = 2'b10;
      @(negedge clk);            // EXEC: requester 0 pulses for one cycle
      req_valid = 2'b01;
      #1;
      total++;
      if (req_ready !== 2'b00) begin
         bad++;
         $display("FAIL wd_busy_ready: got %b want 00", req_ready);
      end
      @(negedge clk);
      req_valid = 2'b00;
      grants = 0;
      rsps   = 0;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (req_ready !== 2'b00) grants++;
         if (rsp_valid === 1'b1) begin
            rsps++;
            total++;
            if (rsp_id !== 1'b1 || rsp_data !== 16'd30) begin
               bad++;
               $display("FAIL wd_rsp: got id=%b data=%0d want 1 30", rsp_id, rsp_data);
            end
         end
         @(negedge clk);
      end
      total++;
      if (grants != 0 || rsps != 1) begin
         bad++;
         $display("FAIL wd_count: got grants=%0d rsps=%0d want 0 1", grants, rsps);
      end
   endtask

   // -------------------------------------------------------------------------
   initial begin
      rst_n     = 1'b0;
      req_valid = 2'b00;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      rsp_ready = 1'b0;

      test_reset();
      test_single_add();
      test_mul();
      test_back_to_back();
      test_backpressure();
      test_unknown_op();
      test_withdrawn();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
